// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the write-back entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int REG_AW = 4;
  localparam int REG_DW = 32;

  // One pending register write: destination register and result value.
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Youngest-match search over the live queue entries plus the output stage.
// Latency: purely combinational.
// Backpressure: none; a pure lookup.
module wbq_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic [AW-1:0]              addr_i [DEPTH],
  input  logic [DW-1:0]              data_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   rd_ptr_i,
  input  logic [$clog2(DEPTH):0]     count_i,
  input  logic                       regwr_i,
  input  logic [AW-1:0]              rw_i,
  input  logic [DW-1:0]              busw_i,
  input  logic [AW-1:0]              key_i,
  output logic                       hit_o,
  output logic [DW-1:0]              fwd_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0] idx;

  // Scan from the output stage (oldest) through the queue head-to-tail;
  // each later match overrides, so the entry nearest wr_ptr wins.
  always_comb begin
    hit_o = 1'b0;
    fwd_o = '0;
    idx   = '0;
    if (regwr_i && (rw_i == key_i)) begin
      hit_o = 1'b1;
      fwd_o = busw_i;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_i + PW'(k);
      if ((CW'(k) < count_i) && (addr_i[idx] == key_i)) begin
        hit_o = 1'b1;
        fwd_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: buffers register results and drains one per cycle to the register file.
// Latency: 1 cycle from accept to RegWr; throughput 1 write/cycle.
// Backpressure: InReady = (Count < DEPTH) from pre-edge state; Stall holds the drain.
// Optional forwarding lookups (RA/RB -> Hit/Fwd) exist only when WBQ_FWD_EN is defined.
module wb_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [AW-1:0]             InAddr,
  input  logic [DW-1:0]             InData,
  input  logic                      Stall,
  output logic                      RegWr,
  output logic [AW-1:0]             RW,
  output logic [DW-1:0]             BusW,
  output logic                      Empty,
  output logic [$clog2(DEPTH):0]    Count
`ifdef WBQ_FWD_EN
  ,
  input  logic [AW-1:0]             RA,
  input  logic [AW-1:0]             RB,
  output logic                      HitA,
  output logic                      HitB,
  output logic [DW-1:0]             FwdA,
  output logic [DW-1:0]             FwdB
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  // Entry storage is deliberately not reset: pointers alone define what is live.
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          regwr_q,  regwr_d;
  logic [AW-1:0] rw_q,     rw_d;
  logic [DW-1:0] busw_q,   busw_d;

  logic push;
  logic pop;

  // Handshake decode; both use pre-edge occupancy, so a pop never frees a slot
  // for the same cycle and a freshly written entry cannot be popped on its edge.
  always_comb begin
    push = InValid && (count_q != CW'(DEPTH));
    pop  = (count_q != '0) && !Stall;
  end

  // Next-state for pointers, occupancy and the registered write port.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    regwr_d = pop;
    rw_d    = pop ? addr_mem[rd_ptr_q] : rw_q;
    busw_d  = pop ? data_mem[rd_ptr_q] : busw_q;
  end

  // Control state; reset discards everything in flight, including an unpresented write.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      regwr_q  <= 1'b0;
      rw_q     <= '0;
      busw_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      regwr_q  <= regwr_d;
      rw_q     <= rw_d;
      busw_q   <= busw_d;
    end
  end

  // Entry storage write on accept.
  always_ff @(posedge Clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= InAddr;
      data_mem[wr_ptr_q] <= InData;
    end
  end

  // Output port drive.
  always_comb begin
    InReady = (count_q != CW'(DEPTH));
    RegWr   = regwr_q;
    RW      = rw_q;
    BusW    = busw_q;
    Count   = count_q;
    Empty   = (count_q == '0) && !regwr_q;
  end

`ifdef WBQ_FWD_EN
  wbq_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match_a (
    .addr_i   (addr_mem),
    .data_i   (data_mem),
    .rd_ptr_i (rd_ptr_q),
    .count_i  (count_q),
    .regwr_i  (regwr_q),
    .rw_i     (rw_q),
    .busw_i   (busw_q),
    .key_i    (RA),
    .hit_o    (HitA),
    .fwd_o    (FwdA)
  );

  wbq_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match_b (
    .addr_i   (addr_mem),
    .data_i   (data_mem),
    .rd_ptr_i (rd_ptr_q),
    .count_i  (count_q),
    .regwr_i  (regwr_q),
    .rw_i     (rw_q),
    .busw_i   (busw_q),
    .key_i    (RB),
    .hit_o    (HitB),
    .fwd_o    (FwdB)
  );
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenarios plus random traffic against a queue-based model.
// Latency: model retires the head one edge after it becomes visible.
// Backpressure: model accepts only while fewer than DEPTH entries are pending.
module tb_wb_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = REG_AW;
  localparam int DW    = REG_DW;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          InValid;
  logic          InReady;
  logic [AW-1:0] InAddr;
  logic [DW-1:0] InData;
  logic          Stall;
  logic          RegWr;
  logic [AW-1:0] RW;
  logic [DW-1:0] BusW;
  logic          Empty;
  logic [CW-1:0] Count;
  logic [AW-1:0] RA;
  logic [AW-1:0] RB;
`ifdef WBQ_FWD_EN
  logic          HitA;
  logic          HitB;
  logic [DW-1:0] FwdA;
  logic [DW-1:0] FwdB;
`endif

  wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .InValid (InValid),
    .InReady (InReady),
    .InAddr  (InAddr),
    .InData  (InData),
    .Stall   (Stall),
    .RegWr   (RegWr),
    .RW      (RW),
    .BusW    (BusW),
    .Empty   (Empty),
    .Count   (Count)
`ifdef WBQ_FWD_EN
    ,
    .RA      (RA),
    .RB      (RB),
    .HitA    (HitA),
    .HitB    (HitB),
    .FwdA    (FwdA),
    .FwdB    (FwdB)
`endif
  );

  always #5 Clk = ~Clk;

  // Reference model: pending writes in arrival order plus the visible write port.
  wb_entry_t     mq[$];
  logic          m_regwr;
  logic [AW-1:0] m_rw;
  logic [DW-1:0] m_busw;

  int vectors     = 0;
  int miscompares = 0;
  int wr_seen     = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest pending value for a register: newest queued write, else the visible write.
  task automatic model_fwd(input logic [AW-1:0] key, output logic hit, output logic [DW-1:0] val);
    hit = 1'b0;
    val = '0;
    if (m_regwr && m_rw == key) begin
      hit = 1'b1;
      val = m_busw;
    end
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].addr == key) begin
        hit = 1'b1;
        val = mq[i].data;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic          h;
    logic [DW-1:0] v;
    chk({tag, ".RegWr"},   RegWr,   m_regwr);
    chk({tag, ".RW"},      RW,      m_rw);
    chk({tag, ".BusW"},    BusW,    m_busw);
    chk({tag, ".Count"},   Count,   mq.size());
    chk({tag, ".InReady"}, InReady, mq.size() < DEPTH);
    chk({tag, ".Empty"},   Empty,   (mq.size() == 0) && !m_regwr);
`ifdef WBQ_FWD_EN
    model_fwd(RA, h, v);
    chk({tag, ".HitA"}, HitA, h);
    chk({tag, ".FwdA"}, FwdA, v);
    model_fwd(RB, h, v);
    chk({tag, ".HitB"}, HitB, h);
    chk({tag, ".FwdB"}, FwdB, v);
`else
    model_fwd(RA, h, v);
`endif
  endtask

  // One clock: decide the model's push/pop from pre-edge state, advance, compare.
  task automatic cycle(input string tag);
    bit        push, pop;
    wb_entry_t e;
    push = InValid && (mq.size() < DEPTH);
    pop  = (mq.size() > 0) && !Stall;
    e.addr = InAddr;
    e.data = InData;
    @(posedge Clk);
    #1;
    if (pop) begin
      wb_entry_t h;
      h       = mq.pop_front();
      m_regwr = 1'b1;
      m_rw    = h.addr;
      m_busw  = h.data;
    end else begin
      m_regwr = 1'b0;
    end
    if (push) mq.push_back(e);
    if (RegWr === 1'b1) wr_seen++;
    check_all(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_regwr = 1'b0;
    m_rw    = '0;
    m_busw  = '0;
  endtask

  // Assert reset between edges, check the immediate clear, release after one edge.
  task automatic pulse_reset(input string tag);
    Rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    InValid = 1'b0;
    Stall   = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) cycle(tag);
  endtask

  initial begin
    Rst     = 1'b1;
    InValid = 1'b0;
    InAddr  = '0;
    InData  = '0;
    Stall   = 1'b0;
    RA      = '0;
    RB      = '0;
    model_reset();
    #1;
    check_all("reset");
    chk("reset.Count0", Count, 0);
    chk("reset.InReady1", InReady, 1);
    @(posedge Clk);
    #1;
    Rst = 1'b0;

    // Single write: visible one cycle after accept, for exactly one cycle.
    InValid = 1'b1; InAddr = 4'd3; InData = 32'hDEADBEEF;
    cycle("single.acc");
    InValid = 1'b0;
    cycle("single.out");
    chk("single.RegWr", RegWr, 1);
    chk("single.RW", RW, 3);
    chk("single.BusW", BusW, 32'hDEADBEEF);
    cycle("single.after");
    chk("single.Empty", Empty, 1);
    chk("single.RegWr0", RegWr, 0);

    // Fill under stall: 4 of 5 accepted, then drain in order once released.
    Stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      InValid = 1'b1; InAddr = AW'(i); InData = DW'(i * 16);
      cycle("fill");
    end
    chk("fill.Count4", Count, 4);
    chk("fill.InReady0", InReady, 0);
    Stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cycle("fill.drain");
      chk("fill.order", RW, AW'(i));
    end
    InValid = 1'b0;
    drain("fill.tail");

    // Forwarding priority: two writes to r7, youngest must win.
    Stall = 1'b1; RA = 4'd7; RB = 4'd9;
    InValid = 1'b1; InAddr = 4'd7; InData = 32'hA;
    cycle("fwd.a");
    InData = 32'hB;
    cycle("fwd.b");
    InValid = 1'b0;
    cycle("fwd.hold");
`ifdef WBQ_FWD_EN
    chk("fwd.HitA", HitA, 1);
    chk("fwd.FwdA", FwdA, 32'hB);
    chk("fwd.HitB", HitB, 0);
    chk("fwd.FwdB", FwdB, 0);
`endif
    drain("fwd.drain");

    // Wrap-around: 10 back-to-back writes with continuous drain.
    wr_seen = 0;
    Stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      InValid = 1'b1; InAddr = AW'(i + 2); InData = 32'h1000 + DW'(i);
      cycle("wrap");
    end
    InValid = 1'b0;
    cycle("wrap.last");
    chk("wrap.writes", wr_seen, 10);
    cycle("wrap.end");
    chk("wrap.Count0", Count, 0);

    // Reset mid-operation: queued writes must never appear.
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      InValid = 1'b1; InAddr = AW'(i + 10); InData = DW'(i + 32'h500);
      cycle("rst.fill");
    end
    InValid = 1'b0;
    pulse_reset("rst.mid");
    chk("rst.RegWr0", RegWr, 0);
    Stall = 1'b0;
    wr_seen = 0;
    for (int i = 0; i < 4; i++) cycle("rst.after");
    chk("rst.nowrites", wr_seen, 0);

    // Random traffic with bursts of stall and one reset in the middle.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        InValid = 1'b0;
        pulse_reset("rand.rst");
      end
      InValid = ($urandom_range(0, 3) != 0);
      InAddr  = AW'($urandom_range(0, 7));
      InData  = $urandom;
      if ($urandom_range(0, 7) == 0) Stall = ~Stall;
      RA      = AW'($urandom_range(0, 7));
      RB      = AW'($urandom_range(0, 7));
      cycle("rand");
    end
    drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
# wb_queue

Write-back queue between the execute/memory stages and `RegisterFile`. It accepts register results through a valid/ready port, buffers them in a small circular FIFO, and drains one per cycle onto the register-file write port (`RegWr`/`RW`/`BusW`). It also offers forwarding lookups, so decode can see values that are still pending and not yet written.

## Interface
Parameters:
- `DEPTH`, 4, number of queue entries; power of two, 2..16.
- `AW`, 4, register address width; matches the 16-entry register file.
- `DW`, 32, data width.

Ports:
- `Clk` in 1: sole clock, rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `InValid` in 1: producer has a result.
- `InReady` out 1: queue can accept; equals `count < DEPTH`.
- `InAddr` in AW: destination register.
- `InData` in DW: result value.
- `Stall` in 1: holds the drain; no pop while high.
- `RegWr` out 1: register-file write enable (registered).
- `RW` out AW: register-file write address (registered).
- `BusW` out DW: register-file write data (registered).
- `Empty` out 1: `count == 0` and `RegWr == 0`.
- `Count` out $clog2(DEPTH)+1: current occupancy.
- `RA`, `RB` in AW: lookup addresses. Present only with `WBQ_FWD_EN`.
- `HitA`, `HitB` out 1: a pending write matches. Present only with `WBQ_FWD_EN`.
- `FwdA`, `FwdB` out DW: forwarded data. Present only with `WBQ_FWD_EN`.

## Operation
- Storage is a circular buffer with `wr_ptr`, `rd_ptr` (each $clog2(DEPTH) bits, wrapping modulo DEPTH) and `count`.
- **Enqueue:** on a rising edge with `InValid && InReady`, write `{InAddr, InData}` at `wr_ptr`, then increment `wr_ptr`.
- **Dequeue:** on a rising edge with `count > 0 && !Stall`, load the head into `RW`/`BusW`, set `RegWr = 1`, and increment `rd_ptr`. Otherwise `RegWr <= 0`, and `RW`/`BusW` hold their values.
- **Simultaneous enqueue and dequeue:** `count` is unchanged; both pointers advance.
- **Full:** `InReady` is computed from the pre-edge `count`. A pop in the same cycle does not raise `InReady`, and there is no combinational ready-through.
- **Empty:** no pop, and `RegWr` is 0 the next cycle. An entry is never popped in the same cycle it is enqueued.
- **Ordering:** strict FIFO. Writes to the same register retire in arrival order, so the last write wins in the register file.
- **Reset:**
  - `Rst` is asynchronous and takes priority over all other activity.
  - It clears `wr_ptr`, `rd_ptr` and `count`, and sets `RegWr = 0`, `RW = 0`, `BusW = 0`.
  - Entries in flight are discarded. Entry storage is not cleared.
  - Asserting `Rst` mid-drain suppresses any write not yet presented.
- **Stall held:** the queue keeps accepting until full. Data is never lost or reordered.

## Timing
- Accept at edge N with the queue empty and `Stall` low gives `RegWr = 1` during cycle N+1. The register file captures it at edge N+2.
- Minimum latency is 1 cycle to the outputs. Throughput is 1 write per cycle.
- Forwarding outputs are combinational from `RA`/`RB` and the current state. No edge is involved.
- Reset values: `RegWr` = 0, `RW` = 0, `BusW` = 0, `InReady` = 1, `Empty` = 1, `Count` = 0, `HitA`/`HitB` = 0, `FwdA`/`FwdB` = 0.

## Configuration
`WBQ_FWD_EN` defined:
- The lookup ports exist.
- `HitA` is set if `RA` matches any valid queue entry or the output stage (`RegWr && RW == RA`).
- `FwdA` returns the youngest matching value. Priority is queue entry nearest `wr_ptr` first, then oldest, then the output stage.
- With no match, `FwdA = 0`. `RB` behaves the same way.

`WBQ_FWD_EN` undefined:
- The `RA`/`RB`/`Hit*`/`Fwd*` ports and the comparison logic are absent.
- The queue behaves identically otherwise.

## Structure
- Shared package `cpu_pkg`:
  - `REG_AW = 4` and `REG_DW = 32`.
  - typedef `wb_entry_t {addr, data}`.
- One sub-module, `wbq_match`: parameterized youngest-match priority search over DEPTH entries plus the output stage. It is instantiated twice (A and B) under `WBQ_FWD_EN`.

## Test plan
- **Single write:** enqueue `{3, 0xDEADBEEF}` into an empty queue with `Stall=0` → `RegWr=1`, `RW=3`, `BusW=0xDEADBEEF` for exactly one cycle, one cycle after the accept. `Empty=1` afterwards.
- **Fill under stall:** `Stall=1`, offer 5 writes (regs 1..5, data 0x10..0x50) at `DEPTH=4` → 4 accepted, `InReady=0`, `Count=4`. Release `Stall` → writes to 1,2,3,4 on consecutive cycles, then reg 5 is accepted.
- **Forward priority (`WBQ_FWD_EN`):** queue `{7,0xA}`, `{7,0xB}` with `Stall=1` and `RA=7` → `HitA=1`, `FwdA=0xB`. With `RB=9` → `HitB=0`, `FwdB=0`.
- **Wrap-around:** 10 back-to-back writes with continuous drain at `DEPTH=4` → all 10 are presented in order with no gaps after the first. Pointers wrap, and the final `Count=0`.
- **Reset mid-operation:** 3 entries queued and `Stall=1`, assert `Rst` between edges → outputs clear immediately (`RegWr=0`, `Count=0`, `InReady=1`). No queued write appears after `Rst` is released.
